muldiv_unit: RTL and testbench



---
 rtl/mips_pkg.sv | 21 ++
 rtl/muldiv_unit.sv | 149 ++++++++++++++
 tb/tb_muldiv_unit.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared types and constants for the multiply/divide unit and its neighbours in the datapath.
package mips_pkg;

    localparam int MD_WIDTH = 32;

    typedef enum logic [1:0] {
        MD_MULT  = 2'b00,
        MD_MULTU = 2'b01,
        MD_DIV   = 2'b10,
        MD_DIVU  = 2'b11
    } muldiv_op_t;

    typedef enum logic [1:0] {
        MD_IDLE = 2'b00,
        MD_RUN  = 2'b01,
        MD_FIX  = 2'b10
    } muldiv_state_t;

    localparam logic [MD_WIDTH-1:0] MD_DIV0_LO = '1;

endpackage

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU engine owning the HI/LO pair.
// Works on magnitudes for WIDTH cycles, then applies sign fixes in one extra cycle.
module muldiv_unit
    import mips_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             mthi,
    input  logic             mtlo,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    muldiv_state_t      state_q;
    muldiv_op_t         op_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               sa_q;
    logic               sb_q;
    logic [WIDTH-1:0]   opnd_q;   // multiplicand (mult) or divisor (div)
    logic [2*WIDTH-1:0] acc_q;    // product accumulator; low half is dividend/quotient for div
    logic [WIDTH-1:0]   rem_q;
    logic               busy_q;
    logic               done_q;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;

    muldiv_op_t         op_in;
    logic               in_signed;
    logic               in_div;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;

    assign op_in     = muldiv_op_t'(op);
    assign in_signed = (op_in == MD_MULT) || (op_in == MD_DIV);
    assign in_div    = (op_in == MD_DIV) || (op_in == MD_DIVU);
    assign mag_a     = (in_signed && a[WIDTH-1]) ? -a : a;
    assign mag_b     = (in_signed && b[WIDTH-1]) ? -b : b;

    logic               run_div;
    logic               run_signed;
    logic [WIDTH:0]     mul_sum_d;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH+1:0]   div_trial;
    logic               div_ge;
    logic [WIDTH-1:0]   rem_d;

    assign run_div    = (op_q == MD_DIV) || (op_q == MD_DIVU);
    assign run_signed = (op_q == MD_MULT) || (op_q == MD_DIV);

    assign mul_sum_d = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? opnd_q : '0)};

    // Restoring step: the trial result is valid only if it is non-negative and below 2^WIDTH.
    assign div_shift = {rem_q, acc_q[WIDTH-1]};
    assign div_trial = {1'b0, div_shift} - {2'b00, opnd_q};
    assign div_ge    = (div_trial[WIDTH+1:WIDTH] == 2'b00);
    assign rem_d     = div_ge ? div_trial[WIDTH-1:0] : div_shift[WIDTH-1:0];

    logic               neg_res;
    logic               neg_rem;
    logic               div_by_zero;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;
    logic [WIDTH-1:0]   hi_d;
    logic [WIDTH-1:0]   lo_d;

    assign neg_res     = run_signed && (sa_q ^ sb_q);
    assign neg_rem     = run_signed && sa_q;
    assign div_by_zero = (opnd_q == '0);
    assign prod_fix    = neg_res ? -acc_q : acc_q;
    assign quo_fix     = neg_res ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    assign rem_fix     = neg_rem ? -rem_q : rem_q;

    // A zero divisor leaves the dividend in the remainder, so only LO needs overriding.
    assign hi_d = run_div ? rem_fix : prod_fix[2*WIDTH-1:WIDTH];
    assign lo_d = run_div ? (div_by_zero ? WIDTH'(MD_DIV0_LO) : quo_fix) : prod_fix[WIDTH-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= MD_IDLE;
            op_q    <= MD_MULT;
            cnt_q   <= '0;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            opnd_q  <= '0;
            acc_q   <= '0;
            rem_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                MD_IDLE: begin
                    if (start) begin
                        op_q    <= op_in;
                        sa_q    <= a[WIDTH-1];
                        sb_q    <= b[WIDTH-1];
                        cnt_q   <= '0;
                        rem_q   <= '0;
                        opnd_q  <= in_div ? mag_b : mag_a;
                        acc_q   <= {{WIDTH{1'b0}}, (in_div ? mag_a : mag_b)};
                        busy_q  <= 1'b1;
                        state_q <= MD_RUN;
                    end else begin
                        if (mthi) hi_q <= a;
                        if (mtlo) lo_q <= a;
                    end
                end
                MD_RUN: begin
                    if (run_div) begin
                        acc_q[WIDTH-1:0] <= {acc_q[WIDTH-2:0], div_ge};
                        rem_q            <= rem_d;
                    end else begin
                        acc_q <= {mul_sum_d, acc_q[WIDTH-1:1]};
                    end
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) state_q <= MD_FIX;
                end
                MD_FIX: begin
                    hi_q    <= hi_d;
                    lo_q    <= lo_d;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= MD_IDLE;
                end
                default: state_q <= MD_IDLE;
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Randomized and directed bench for muldiv_unit against a cycle-level arithmetic model.
module tb_muldiv_unit;

    localparam int W   = 32;
    localparam int LAT = W + 1;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         mthi  = 1'b0;
    logic         mtlo  = 1'b0;
    logic [1:0]   op    = 2'b00;
    logic [W-1:0] a     = '0;
    logic [W-1:0] b     = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    muldiv_unit #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .mthi  (mthi),
        .mtlo  (mtlo),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Architectural result {HI, LO} straight from the instruction semantics.
    function automatic logic [63:0] ref_calc(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        longint p;
        int q;
        int r;
        case (o)
            2'd0: begin
                p = longint'($signed(x)) * longint'($signed(y));
                return p;
            end
            2'd1: return {32'd0, x} * {32'd0, y};
            2'd2: begin
                if (y == 0) return {x, 32'hFFFFFFFF};
                if (x == 32'h80000000 && y == 32'hFFFFFFFF) return {32'h0, 32'h80000000};
                q = $signed(x) / $signed(y);
                r = $signed(x) % $signed(y);
                return {r, q};
            end
            default: begin
                if (y == 0) return {x, 32'hFFFFFFFF};
                return {x % y, x / y};
            end
        endcase
    endfunction

    logic [W-1:0]   m_hi   = '0;
    logic [W-1:0]   m_lo   = '0;
    logic           m_done = 1'b0;
    int             m_cnt  = 0;
    logic [2*W-1:0] m_pend = '0;

    always @(posedge clk) begin
        if (rst_n) begin
            m_done = 1'b0;
            if (m_cnt == 0) begin
                if (start) begin
                    m_pend = ref_calc(op, a, b);
                    m_cnt  = LAT;
                end else begin
                    if (mthi) m_hi = a;
                    if (mtlo) m_lo = a;
                end
            end else begin
                m_cnt--;
                if (m_cnt == 0) begin
                    {m_hi, m_lo} = m_pend;
                    m_done = 1'b1;
                end
            end
        end
    end

    always @(negedge rst_n) begin
        m_hi   = '0;
        m_lo   = '0;
        m_done = 1'b0;
        m_cnt  = 0;
    end

    always @(negedge clk) begin
        check("busy", 64'(busy), 64'(m_cnt != 0));
        check("done", 64'(done), 64'(m_done));
        check("hi", 64'(hi), 64'(m_hi));
        check("lo", 64'(lo), 64'(m_lo));
    end

    task automatic issue(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic mh, input logic ml);
        op = o; a = x; b = y; start = 1'b1; mthi = mh; mtlo = ml;
        @(posedge clk); #1;
        start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
    endtask

    task automatic wait_done(input int exp_lat, input string name);
        int k;
        for (k = 1; k <= 100; k++) begin
            @(posedge clk); #1;
            if (done) break;
        end
        check({name, "_latency"}, 64'(k), 64'(exp_lat));
    endtask

    task automatic do_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic mh, input logic ml, input string name);
        issue(o, x, y, mh, ml);
        wait_done(LAT, name);
        $display("%s op=%0d a=%h b=%h -> hi=%h lo=%h", name, o, x, y, hi, lo);
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 7))
            0: return '0;
            1: return 32'd1;
            2: return 32'hFFFFFFFF;
            3: return 32'h80000000;
            4: return 32'($urandom_range(0, 255));
            5: return -32'($urandom_range(1, 255));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #20000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_hi", 64'(hi), 64'd0);
        rst_n = 1'b1;

        do_op(2'd0, 32'hFFFFFFFD, 32'd5, 1'b0, 1'b0, "mult_neg");
        check("mult_neg_hi", 64'(hi), 64'hFFFFFFFF);
        check("mult_neg_lo", 64'(lo), 64'hFFFFFFF1);
        check("mult_done_nobusy", 64'(busy), 64'd0);

        do_op(2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, "multu_max");
        check("multu_max_hi", 64'(hi), 64'hFFFFFFFE);
        check("multu_max_lo", 64'(lo), 64'h00000001);
        do_op(2'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, "mult_m1");
        check("mult_m1_hi", 64'(hi), 64'h0);
        check("mult_m1_lo", 64'(lo), 64'h1);

        do_op(2'd2, -32'd7, 32'd2, 1'b0, 1'b0, "div_m7");
        check("div_m7_lo", 64'(lo), 64'hFFFFFFFD);
        check("div_m7_hi", 64'(hi), 64'hFFFFFFFF);
        do_op(2'd3, 32'd7, 32'd0, 1'b0, 1'b0, "divu_zero");
        check("divu_zero_hi", 64'(hi), 64'h7);
        check("divu_zero_lo", 64'(lo), 64'hFFFFFFFF);

        do_op(2'd2, 32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b0, "div_ovf");
        check("div_ovf_lo", 64'(lo), 64'h80000000);
        check("div_ovf_hi", 64'(hi), 64'h0);
        issue(2'd1, 32'h00010000, 32'h30, 1'b0, 1'b0);
        check("b2b_busy", 64'(busy), 64'd1);

        // Ignored requests while running.
        repeat (5) begin @(posedge clk); #1; end
        issue(2'd3, 32'd9, 32'd3, 1'b0, 1'b0);
        a = 32'h1234; mthi = 1'b1;
        @(posedge clk); #1;
        mthi = 1'b0;
        wait_done(LAT - 7, "run_ignore");
        check("run_ignore_hi", 64'(hi), 64'h0);
        check("run_ignore_lo", 64'(lo), 64'h00300000);
        a = 32'h1234; mthi = 1'b1;
        @(posedge clk); #1;
        mthi = 1'b0;
        check("mthi_hi", 64'(hi), 64'h1234);
        check("mthi_lo", 64'(lo), 64'h00300000);

        // Asynchronous reset mid-operation.
        issue(2'd1, 32'd5, 32'd6, 1'b0, 1'b0);
        repeat (10) begin @(posedge clk); #1; end
        #2 rst_n = 1'b0;
        #1;
        check("arst_busy", 64'(busy), 64'd0);
        check("arst_done", 64'(done), 64'd0);
        check("arst_hi", 64'(hi), 64'd0);
        check("arst_lo", 64'(lo), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        do_op(2'd1, 32'd3, 32'd4, 1'b0, 1'b0, "multu_3x4");
        check("multu_3x4_lo", 64'(lo), 64'd12);
        check("multu_3x4_hi", 64'(hi), 64'd0);

        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 9) < 2) begin
                a = $urandom; mthi = 1'($urandom_range(0, 1)); mtlo = 1'($urandom_range(0, 1));
                @(posedge clk); #1;
                mthi = 1'b0; mtlo = 1'b0;
                $display("move mthi/mtlo a=%h -> hi=%h lo=%h", a, hi, lo);
            end else begin
                do_op(2'($urandom_range(0, 3)), pick(), pick(),
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), "rand");
                repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            end
        end

        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
